// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, buffers one instruction while frozen.
// Optional counters fetch_count/stall_count exist only when FETCH_STATS_EN is defined.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] NPC,
  output logic        instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_npc;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_target;
  logic        w_from_buf;
  logic        w_instr_valid;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_target = redirect_pc & ~32'h3;
  assign w_from_buf        = (r_state != S_FETCH);

  // nRST gating keeps a stray ihit from looking like a valid fetch during reset.
  assign w_instr_valid = nRST && !halt && !redirect &&
                         ((r_state == S_FETCH) ? ihit : (r_state == S_HOLD));

  assign imemREN     = (r_state == S_FETCH);
  assign imemaddr    = r_pc;
  assign instr       = w_from_buf ? r_buf_instr : imemload;
  assign NPC         = w_from_buf ? r_buf_npc   : w_pc_plus4;
  assign instr_valid = w_instr_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_FETCH;
      r_pc        <= PC_INIT;
      r_buf_instr <= 32'd0;
      r_buf_npc   <= 32'd0;
    end else if (r_state != S_HALTED) begin
      if (halt) begin
        r_state <= S_HALTED;
      end else if (redirect) begin
        r_pc    <= w_redirect_target;
        r_state <= S_FETCH;
      end else if (r_state == S_HOLD) begin
        if (!freeze) r_state <= S_FETCH;
      end else if (ihit) begin
        // The PC advances even when frozen; the buffer remembers the captured NPC.
        r_pc <= w_pc_plus4;
        if (freeze) begin
          r_buf_instr <= imemload;
          r_buf_npc   <= w_pc_plus4;
          r_state     <= S_HOLD;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_transfer;
  logic        w_stall;

  assign w_transfer = w_instr_valid && !freeze;
  assign w_stall    = ((r_state == S_FETCH) && !ihit) || (w_instr_valid && freeze);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else if (r_state != S_HALTED) begin
      if (w_transfer && (r_fetch_count != 32'hFFFF_FFFF)) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF))    r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, randomized model check.
// Counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'd0;
  logic        freeze = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic [31:0] NPC;
  logic        instr_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .freeze(freeze),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr), .NPC(NPC),
    .instr_valid(instr_valid)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a PC, an optional single held instruction, and a halted latch.
  logic [31:0] m_pc, m_bi, m_bn, m_fc, m_sc;
  bit          m_held, m_halted;

  function automatic void model_reset();
    m_pc = 32'd0; m_bi = 32'd0; m_bn = 32'd0; m_fc = 32'd0; m_sc = 32'd0;
    m_held = 1'b0; m_halted = 1'b0;
  endfunction

  function automatic bit exp_valid();
    return nRST && !m_halted && (m_held || ihit) && !halt && !redirect;
  endfunction

  task automatic check_model(input string tag);
    bit from_buf;
    from_buf = m_held || m_halted;
    chk({tag, ".ren"},   {31'd0, imemREN},     {31'd0, !from_buf});
    chk({tag, ".addr"},  imemaddr,             m_pc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, exp_valid()});
    chk({tag, ".instr"}, instr,                from_buf ? m_bi : imemload);
    chk({tag, ".npc"},   NPC,                  from_buf ? m_bn : m_pc + 32'd4);
`ifdef FETCH_STATS_EN
    chk({tag, ".fcnt"},  fetch_count, m_fc);
    chk({tag, ".scnt"},  stall_count, m_sc);
`endif
  endtask

  function automatic void model_step();
    bit v;
    v = exp_valid();
    if (!m_halted) begin
      if (v && !freeze && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
      if (((!m_held && !ihit) || (v && freeze)) && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
      if (halt) m_halted = 1'b1;
      else if (redirect) begin
        m_pc = redirect_pc & ~32'h3;
        m_held = 1'b0;
      end else if (m_held) begin
        if (!freeze) m_held = 1'b0;
      end else if (ihit) begin
        if (freeze) begin
          m_bi = imemload;
          m_bn = m_pc + 32'd4;
          m_held = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic drive(input bit ih, input logic [31:0] d, input bit fz, input bit rd,
                       input logic [31:0] rpc, input bit hl);
    ihit = ih; imemload = d; freeze = fz; redirect = rd; redirect_pc = rpc; halt = hl;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset mid-cycle, checks reset outputs with ihit high, releases away from the edge.
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk("rst.ren",   {31'd0, imemREN},     32'd1);
    chk("rst.addr",  imemaddr,             32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.npc",   NPC,                  32'd4);
`ifdef FETCH_STATS_EN
    chk("rst.fcnt",  fetch_count, 32'd0);
    chk("rst.scnt",  stall_count, 32'd0);
`endif
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    model_reset();
  endtask

  typedef struct {
    bit          ih, fz, rd, hl;
    logic [31:0] d, rpc;
    bit          e_ren, e_val;
    logic [31:0] e_addr, e_instr, e_npc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // ih fz rd hl  data  rpc          ren val addr   instr  npc
    tbl[0]  = '{1, 0, 0, 0, 32'hA000_0000, 32'd0,     1, 1, 32'd0,   32'hA000_0000, 32'd4};
    tbl[1]  = '{1, 0, 0, 0, 32'hA000_0001, 32'd0,     1, 1, 32'd4,   32'hA000_0001, 32'd8};
    tbl[2]  = '{0, 0, 0, 0, 32'd0,         32'd0,     1, 0, 32'd8,   32'd0,         32'd12};
    tbl[3]  = '{0, 0, 0, 0, 32'd0,         32'd0,     1, 0, 32'd8,   32'd0,         32'd12};
    tbl[4]  = '{0, 0, 0, 0, 32'd0,         32'd0,     1, 0, 32'd8,   32'd0,         32'd12};
    tbl[5]  = '{1, 0, 0, 0, 32'hA000_0002, 32'd0,     1, 1, 32'd8,   32'hA000_0002, 32'd12};
    tbl[6]  = '{1, 0, 0, 0, 32'hA000_0003, 32'd0,     1, 1, 32'd12,  32'hA000_0003, 32'd16};
    tbl[7]  = '{1, 1, 0, 0, 32'hA000_0004, 32'd0,     1, 1, 32'd16,  32'hA000_0004, 32'd20};
    tbl[8]  = '{0, 1, 0, 0, 32'h0000_DEAD, 32'd0,     0, 1, 32'd20,  32'hA000_0004, 32'd20};
    tbl[9]  = '{0, 1, 0, 0, 32'h0000_DEAD, 32'd0,     0, 1, 32'd20,  32'hA000_0004, 32'd20};
    tbl[10] = '{0, 0, 0, 0, 32'h0000_DEAD, 32'd0,     0, 1, 32'd20,  32'hA000_0004, 32'd20};
    tbl[11] = '{1, 1, 0, 0, 32'hA000_0005, 32'd0,     1, 1, 32'd20,  32'hA000_0005, 32'd24};
    tbl[12] = '{0, 1, 1, 0, 32'd0,         32'h103,   0, 0, 32'd24,  32'hA000_0005, 32'd24};
    tbl[13] = '{0, 0, 0, 0, 32'd0,         32'd0,     1, 0, 32'h100, 32'd0,         32'h104};
    tbl[14] = '{1, 0, 1, 1, 32'hA000_0006, 32'h200,   1, 0, 32'h100, 32'hA000_0006, 32'h104};
    tbl[15] = '{1, 0, 0, 0, 32'hA000_0007, 32'd0,     0, 0, 32'h100, 32'hA000_0005, 32'd24};
    tbl[16] = '{1, 0, 1, 0, 32'hA000_0007, 32'h300,   0, 0, 32'h100, 32'hA000_0005, 32'd24};

    #1;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].ih, tbl[i].d, tbl[i].fz, tbl[i].rd, tbl[i].rpc, tbl[i].hl);
      #4;
      $display("vec %0d: ren=%0b addr=%h valid=%0b instr=%h npc=%h",
               i, imemREN, imemaddr, instr_valid, instr, NPC);
      chk($sformatf("vec%0d.ren", i),   {31'd0, imemREN},     {31'd0, tbl[i].e_ren});
      chk($sformatf("vec%0d.addr", i),  imemaddr,             tbl[i].e_addr);
      chk($sformatf("vec%0d.valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_val});
      chk($sformatf("vec%0d.instr", i), instr,                tbl[i].e_instr);
      chk($sformatf("vec%0d.npc", i),   NPC,                  tbl[i].e_npc);
      adv();
    end

    // Halted persists until reset, which returns fetch to the reset PC.
    do_reset();
    #4;
    chk("post_halt.addr", imemaddr, 32'd0);
    chk("post_halt.ren",  {31'd0, imemREN}, 32'd1);
    adv();

    // PC wrap at the top of the address space; redirect low bits are dropped.
    drive(1'b1, 32'hBEEF_0000, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    #4;
    chk("wrap.rd_valid", {31'd0, instr_valid}, 32'd0);
    adv();
    drive(1'b1, 32'hBEEF_0001, 1'b0, 1'b0, 32'd0, 1'b0);
    #4;
    $display("wrap: addr=%h npc=%h valid=%0b", imemaddr, NPC, instr_valid);
    chk("wrap.addr",  imemaddr, 32'hFFFF_FFFC);
    chk("wrap.npc",   NPC,      32'd0);
    chk("wrap.valid", {31'd0, instr_valid}, 32'd1);
    adv();
    #4;
    chk("wrap.next_addr", imemaddr, 32'd0);

    // Reset arriving while an instruction is held drops it.
    drive(1'b1, 32'hC0DE_0000, 1'b1, 1'b0, 32'd0, 1'b0);
    adv();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    #1;
    chk("hold.ren",   {31'd0, imemREN}, 32'd0);
    chk("hold.instr", instr, 32'hC0DE_0000);
    #1;
    do_reset();
    drive(1'b1, 32'hC0DE_0001, 1'b0, 1'b0, 32'd0, 1'b0);
    #4;
    $display("after hold reset: addr=%h instr=%h valid=%0b", imemaddr, instr, instr_valid);
    chk("hold_rst.addr",  imemaddr, 32'd0);
    chk("hold_rst.instr", instr, 32'hC0DE_0001);
    chk("hold_rst.valid", {31'd0, instr_valid}, 32'd1);
    adv();

`ifdef FETCH_STATS_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive((i % 3) != 2 || i == 7, 32'h5000_0000 + i, 1'b0, 1'b0, 32'd0, 1'b0);
      adv();
    end
    #4;
    $display("stats: fetch_count=%0d stall_count=%0d", fetch_count, stall_count);
    chk("stats.fcnt", fetch_count, 32'd6);
    chk("stats.scnt", stall_count, 32'd2);
    adv();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 32'h6000_0000 + i, 1'b0, 1'b0, 32'd0, 1'b0);
      adv();
    end
    #4;
    chk("stats5.fcnt", fetch_count, 32'd5);
    chk("stats5.scnt", stall_count, 32'd3);
    adv();
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) begin
        do_reset();
        continue;
      end
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | $urandom_range(0, 3)) : $urandom,
            $urandom_range(0, 79) == 0);
      #4;
      $display("rand %0d: ih=%0b fz=%0b rd=%0b hl=%0b addr=%h valid=%0b instr=%h npc=%h",
               n, ihit, freeze, redirect, halt, imemaddr, instr_valid, instr, NPC);
      check_model($sformatf("rand%0d", n));
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
